// File: rtl/pipe_pkg.sv
// Shared pipeline constants for the register file, ID/EX register and forwarding unit.
package pipe_pkg;

    localparam int         REG_W     = 32;
    localparam int         REG_AW    = 5;
    localparam logic [4:0] REG_ZERO  = 5'd0;
    localparam int         WCNT_W    = 8;
    localparam logic [7:0] WCNT_MAX  = 8'd255;

    // Saturating increment: holds at WCNT_MAX instead of wrapping to zero.
    function automatic logic [WCNT_W-1:0] satInc(input logic [WCNT_W-1:0] value);
        return (value == WCNT_MAX) ? WCNT_MAX : value + 8'd1;
    endfunction

endpackage

// File: rtl/reg_file_rport.sv
// One combinational read port: zero register, optional same-cycle WB forward, else stored row.
module reg_file_rport
    import pipe_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int AW     = REG_AW,
    parameter int BYPASS = 1
) (
    input  logic [AW-1:0]    raddr,
    input  logic [WIDTH-1:0] row,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic             rst,
    output logic [WIDTH-1:0] rdata
);

    logic w_fwd;

    // Forwarding is suppressed during reset because that write is dropped.
    assign w_fwd = (BYPASS != 0) && we && !rst && (wa == raddr);

    always_comb begin
        rdata = '0;
        if (raddr != AW'(REG_ZERO)) begin
            if (w_fwd) begin
                rdata = wd;
            end else begin
                rdata = row;
            end
        end
    end

endmodule

// File: rtl/reg_file.sv
// Pipeline register file: two async read ports, one WB write port, saturating write counter.
module reg_file
    import pipe_pkg::*;
#(
    parameter int WIDTH  = REG_W,
    parameter int AW     = REG_AW,
    parameter int BYPASS = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    output logic [7:0]       wcnt
);

    localparam int DEPTH = 2**AW;

    logic [WIDTH-1:0] r_mem [0:DEPTH-1];
    logic [7:0]       r_wcnt;
    logic [WIDTH-1:0] w_row1;
    logic [WIDTH-1:0] w_row2;
    logic             w_commit;

    assign w_commit = we && (wa != AW'(REG_ZERO));

    // Every row is cleared on reset so no X ever reaches the read ports.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= '0;
            end
            r_wcnt <= '0;
        end else if (w_commit) begin
            r_mem[wa] <= wd;
            r_wcnt    <= satInc(r_wcnt);
        end
    end

    assign w_row1 = r_mem[ra1];
    assign w_row2 = r_mem[ra2];
    assign wcnt   = r_wcnt;

    reg_file_rport #(.WIDTH(WIDTH), .AW(AW), .BYPASS(BYPASS)) u_rport1 (
        .raddr (ra1),
        .row   (w_row1),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .rst   (rst),
        .rdata (rd1)
    );

    reg_file_rport #(.WIDTH(WIDTH), .AW(AW), .BYPASS(BYPASS)) u_rport2 (
        .raddr (ra2),
        .row   (w_row2),
        .we    (we),
        .wa    (wa),
        .wd    (wd),
        .rst   (rst),
        .rdata (rd2)
    );

endmodule
